m3_motor_seq_ctrl: RTL

Run-sequence controller for the 3-phase motor round calculator. It turns user-level commands (run, direction, target period, e-stop) into the calculator's start, forceStop, invRotate and speed INC/DEC strobes. It ramps speed toward a target round period, performs a controlled slow-down before stop or direction reversal, and handles emergency stop. It sits between the panel/command logic and the round calculator, and closes the loop on the calculator's current round length.

---
 rtl/m3_ctrl_pkg.sv | 22 ++
 rtl/m3_motor_seq_ctrl_period_cmp.sv | 35 +++
 rtl/m3_motor_seq_ctrl.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/m3_ctrl_pkg.sv
// Shared encodings and period defaults for the 3-phase motor run-sequence controller.
package m3_ctrl_pkg;

  localparam int unsigned DEF_PERIOD_W = 22;
  localparam logic [DEF_PERIOD_W-1:0] DEF_PERIOD_MIN = 22'd40;
  localparam logic [DEF_PERIOD_W-1:0] DEF_PERIOD_MAX = 22'd4000000;
  localparam logic [DEF_PERIOD_W-1:0] SIM_PERIOD_MAX = 22'd300;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    RUN      = 3'd1,
    SLOWDOWN = 3'd2,
    DWELL    = 3'd3,
    ESTOP    = 3'd4
  } state_t;

  typedef enum logic {
    STOP = 1'b0,
    REV  = 1'b1
  } reason_t;

endpackage

// File: rtl/m3_motor_seq_ctrl_period_cmp.sv
// Target clamp and hysteresis compare against the calculator's current round length.
module m3_period_cmp
  import m3_ctrl_pkg::*;
#(
  parameter int unsigned           PERIOD_W   = DEF_PERIOD_W,
  parameter logic [PERIOD_W-1:0]   PERIOD_MIN = DEF_PERIOD_MIN,
  parameter logic [PERIOD_W-1:0]   PERIOD_MAX = DEF_PERIOD_MAX
) (
  input  logic [PERIOD_W-1:0] tgt,
  input  logic [PERIOD_W-1:0] cur,
  input  logic [PERIOD_W-1:0] hyst,
  output logic                needInc,
  output logic                needDec,
  output logic                atMax
);

  logic [PERIOD_W-1:0] tgtClamp;
  logic [PERIOD_W:0]   tgtX;
  logic [PERIOD_W:0]   curX;
  logic [PERIOD_W:0]   hystX;

  always_comb begin
    if (tgt < PERIOD_MIN)      tgtClamp = PERIOD_MIN;
    else if (tgt > PERIOD_MAX) tgtClamp = PERIOD_MAX;
    else                       tgtClamp = tgt;
    // One extra bit so tgt+hyst and cur+hyst cannot wrap.
    tgtX    = {1'b0, tgtClamp};
    curX    = {1'b0, cur};
    hystX   = {1'b0, hyst};
    needInc = curX > (tgtX + hystX);
    needDec = (curX + hystX) < tgtX;
    atMax   = cur >= PERIOD_MAX;
  end

endmodule

// File: rtl/m3_motor_seq_ctrl.sv
// Run-sequence controller: ramps the round calculator toward a target period, slows
// down before stop/reversal, dwells idle before restart, and handles emergency stop.
module m3_motor_seq_ctrl
  import m3_ctrl_pkg::*;
#(
  parameter int unsigned         PERIOD_W    = DEF_PERIOD_W,
  parameter logic [PERIOD_W-1:0] PERIOD_MAX  = DEF_PERIOD_MAX,
  parameter logic [PERIOD_W-1:0] PERIOD_MIN  = DEF_PERIOD_MIN,
  parameter logic [PERIOD_W-1:0] HYST        = 22'd8,
  parameter int unsigned         STOP_ROUNDS = 4,
  parameter logic [15:0]         DWELL_CYC   = 16'd1000
) (
  input  logic                clkI,
  input  logic                nRstI,
  input  logic                cmdRunI,
  input  logic                cmdDirI,
  input  logic                cmdEstopI,
  input  logic [PERIOD_W-1:0] targetPeriodI,
  input  logic [PERIOD_W-1:0] curPeriodI,
  input  logic                roundTickI,
  output logic                m3startO,
  output logic                m3forceStopO,
  output logic                m3invRotateO,
  output logic                m3speedINCo,
  output logic                m3speedDECo,
  output logic                busyO,
  output logic [2:0]          stateO
);

  localparam int unsigned        TICK_W    = $clog2(STOP_ROUNDS + 1);
  localparam logic [TICK_W-1:0]  TICK_LAST = TICK_W'(STOP_ROUNDS - 1);
  localparam logic [15:0]        DWELL_LAST = DWELL_CYC - 16'd1;

  state_t             stateQ, stateNext;
  reason_t            reasonQ, reasonNext;
  logic               invQ, invNext;
  logic [TICK_W-1:0]  tickCnt, tickNext;
  logic [15:0]        dwellCnt, dwellNext;
  logic               startNext, forceNext, incNext, decNext, busyNext;
  logic               needInc, needDec, atMax;

  m3_period_cmp #(
    .PERIOD_W   (PERIOD_W),
    .PERIOD_MIN (PERIOD_MIN),
    .PERIOD_MAX (PERIOD_MAX)
  ) uCmp (
    .tgt     (targetPeriodI),
    .cur     (curPeriodI),
    .hyst    (HYST),
    .needInc (needInc),
    .needDec (needDec),
    .atMax   (atMax)
  );

  always_ff @(posedge clkI or negedge nRstI) begin
    if (!nRstI) begin
      stateQ       <= IDLE;
      reasonQ      <= STOP;
      invQ         <= 1'b0;
      tickCnt      <= '0;
      dwellCnt     <= '0;
      m3startO     <= 1'b1;
      m3forceStopO <= 1'b0;
      m3speedINCo  <= 1'b0;
      m3speedDECo  <= 1'b0;
      busyO        <= 1'b0;
    end else begin
      stateQ       <= stateNext;
      reasonQ      <= reasonNext;
      invQ         <= invNext;
      tickCnt      <= tickNext;
      dwellCnt     <= dwellNext;
      m3startO     <= startNext;
      m3forceStopO <= forceNext;
      m3speedINCo  <= incNext;
      m3speedDECo  <= decNext;
      busyO        <= busyNext;
    end
  end

  always_comb begin
    stateNext  = stateQ;
    reasonNext = reasonQ;
    invNext    = invQ;
    tickNext   = tickCnt;
    dwellNext  = dwellCnt;
    if (cmdEstopI) begin
      stateNext = ESTOP;
      tickNext  = '0;
      dwellNext = '0;
    end else begin
      case (stateQ)
        IDLE: begin
          if (cmdRunI) begin
            stateNext = RUN;
            invNext   = cmdDirI;
          end
        end
        RUN: begin
          if (!cmdRunI) begin
            stateNext  = SLOWDOWN;
            reasonNext = STOP;
          end else if (cmdDirI != invQ) begin
            stateNext  = SLOWDOWN;
            reasonNext = REV;
          end
        end
        SLOWDOWN: begin
          // Abort is checked before tick counting so a resumed run never parks.
          if (reasonQ == STOP && cmdRunI && cmdDirI == invQ) begin
            stateNext = RUN;
            tickNext  = '0;
          end else if (!atMax) begin
            tickNext = '0;
          end else if (roundTickI) begin
            if (tickCnt == TICK_LAST) begin
              stateNext = DWELL;
              tickNext  = '0;
              dwellNext = '0;
              invNext   = cmdDirI;
            end else begin
              tickNext = tickCnt + TICK_W'(1);
            end
          end
        end
        DWELL: begin
          if (dwellCnt == DWELL_LAST) begin
            dwellNext = '0;
            if (cmdRunI) begin
              stateNext = RUN;
              invNext   = cmdDirI;
            end else begin
              stateNext = IDLE;
            end
          end else begin
            dwellNext = dwellCnt + 16'd1;
          end
        end
        ESTOP: begin
          if (!cmdRunI) stateNext = IDLE;
        end
        default: stateNext = IDLE;
      endcase
    end
  end

  // Outputs are computed from the state being entered, then registered.
  always_comb begin
    startNext = !(stateNext == RUN || stateNext == SLOWDOWN);
    forceNext = stateNext == ESTOP;
    incNext   = stateNext == RUN && needInc;
    decNext   = (stateNext == RUN && needDec) || stateNext == SLOWDOWN;
    busyNext  = stateNext != IDLE;
  end

  assign m3invRotateO = invQ;
  assign stateO       = stateQ;

endmodule
